en_pulse_gen: RTL and testbench

Programmable clock-enable strobe generator; produces the single-cycle `en` strobes consumed by enable-flop storage (`flop_en` style registers) and by enable-gated datapaths. It issues one strobe every `period` cycles, either continuously until stopped or as a burst of `burst_len` strobes followed by a `done` pulse. It sits in the common module library, next to the enable-flop and counter primitives.

---
 rtl/en_pulse_gen_pkg.sv | 13 +
 rtl/cnt_dn.sv | 30 +++
 rtl/en_pulse_gen_defs.vh | 9 +
 rtl/en_pulse_gen.sv | 130 +++++++++++++
 tb/tb_en_pulse_gen.sv | 337 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/en_pulse_gen_pkg.sv
// Shared types and constants for the en_pulse_gen strobe generator.
`include "en_pulse_gen_defs.vh"

package en_pulse_gen_pkg;

    localparam int CNT_W_DEFAULT = 8;

    typedef enum logic {
        IDLE = `ST_IDLE,
        RUN  = `ST_RUN
    } state_t;

endpackage

// File: rtl/cnt_dn.sv
// Loadable down-counter used as the phase counter between strobes.
// Load wins over decrement; the count saturates at zero.
module cnt_dn #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - ONE;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/en_pulse_gen_defs.vh
// State encodings for en_pulse_gen.
// Shared by the design and its bench so both agree on IDLE/RUN.
`ifndef EN_PULSE_GEN_DEFS_VH
`define EN_PULSE_GEN_DEFS_VH

`define ST_IDLE 1'b0
`define ST_RUN  1'b1

`endif

// File: rtl/en_pulse_gen.sv
// Programmable clock-enable strobe generator: one strobe every P cycles,
// either continuously until stopped or as a burst of B strobes ending in done.
module en_pulse_gen
    import en_pulse_gen_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             mode,
    input  logic [CNT_W-1:0] period,
    input  logic [CNT_W-1:0] burst_len,
    output logic             en,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pulse_cnt
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state;
    state_t           state_nxt;

    logic [CNT_W-1:0] p_lat;
    logic [CNT_W-1:0] b_lat;
    logic             mode_lat;

    logic [CNT_W-1:0] pulse_cnt_inc;
    logic             accept;
    logic             issue;
    logic             last;

    logic             phase_zero;
    logic             phase_load;
    logic             phase_dec;
    logic [CNT_W-1:0] phase_load_val;

    assign pulse_cnt_inc = pulse_cnt + ONE;

    cnt_dn #(
        .W(CNT_W)
    ) u_phase (
        .clk      (clk),
        .rst      (rst),
        .load     (phase_load),
        .load_val (phase_load_val),
        .dec      (phase_dec),
        .zero     (phase_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Stop has priority everywhere; the B-th strobe of a burst returns to IDLE
    // on the same edge it is issued, so done lines up with the last en.
    always_comb begin
        state_nxt      = state;
        accept         = 1'b0;
        issue          = 1'b0;
        last           = 1'b0;
        phase_load     = 1'b0;
        phase_load_val = '0;
        phase_dec      = 1'b0;
        case (state)
            IDLE: begin
                if (start && !stop) begin
                    accept     = 1'b1;
                    phase_load = 1'b1;
                    state_nxt  = RUN;
                end
            end
            RUN: begin
                if (stop) begin
                    state_nxt = IDLE;
                end else if (phase_zero) begin
                    issue          = 1'b1;
                    phase_load     = 1'b1;
                    phase_load_val = p_lat - ONE;
                    if (mode_lat && (pulse_cnt_inc == b_lat)) begin
                        last      = 1'b1;
                        state_nxt = IDLE;
                    end
                end else begin
                    phase_dec = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_lat    <= '0;
            b_lat    <= '0;
            mode_lat <= 1'b0;
        end else if (accept) begin
            p_lat    <= (period == '0) ? ONE : period;
            b_lat    <= (burst_len == '0) ? ONE : burst_len;
            mode_lat <= mode;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pulse_cnt <= '0;
            en        <= 1'b0;
            done      <= 1'b0;
        end else begin
            en   <= issue;
            done <= last;
            if (accept) begin
                pulse_cnt <= '0;
            end else if (issue) begin
                pulse_cnt <= pulse_cnt_inc;
            end
        end
    end

    assign busy = (state == RUN);

endmodule

// File: tb/tb_en_pulse_gen.sv
// Self-checking bench for en_pulse_gen: directed scenarios plus random
// traffic, all compared against a time-based behavioural model.
module tb_en_pulse_gen;
    import en_pulse_gen_pkg::*;

    localparam int W = CNT_W_DEFAULT;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         stop;
    logic         mode;
    logic [W-1:0] period;
    logic [W-1:0] burst_len;
    logic         en;
    logic         busy;
    logic         done;
    logic [W-1:0] pulse_cnt;

    int errors = 0;
    int checks = 0;

    // Model: a run started at edge S strobes at edges S+1, S+1+P, ...
    int           edge_n  = 0;
    bit           m_run   = 1'b0;
    int           m_start = 0;
    int           m_p     = 1;
    int           m_b     = 1;
    bit           m_mode  = 1'b0;
    int           m_cnt   = 0;
    logic         exp_en  = 1'b0;
    logic         exp_busy = 1'b0;
    logic         exp_done = 1'b0;
    logic [W-1:0] exp_cnt = '0;

    en_pulse_gen #(
        .CNT_W(W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .mode      (mode),
        .period    (period),
        .burst_len (burst_len),
        .en        (en),
        .busy      (busy),
        .done      (done),
        .pulse_cnt (pulse_cnt)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_run    = 1'b0;
        m_cnt    = 0;
        exp_en   = 1'b0;
        exp_busy = 1'b0;
        exp_done = 1'b0;
        exp_cnt  = '0;
    endtask

    task automatic model_edge(input logic s, input logic st);
        exp_en   = 1'b0;
        exp_done = 1'b0;
        if (!m_run) begin
            if (s && !st) begin
                m_run   = 1'b1;
                m_start = edge_n;
                m_p     = (period == 0) ? 1 : int'(period);
                m_b     = (burst_len == 0) ? 1 : int'(burst_len);
                m_mode  = mode;
                m_cnt   = 0;
            end
        end else if (st) begin
            m_run = 1'b0;
        end else if (((edge_n - m_start - 1) % m_p) == 0) begin
            exp_en = 1'b1;
            m_cnt  = m_cnt + 1;
            if (m_mode && (m_cnt == m_b)) begin
                exp_done = 1'b1;
                m_run    = 1'b0;
            end
        end
        exp_busy = m_run;
        exp_cnt  = m_cnt[W-1:0];
        edge_n   = edge_n + 1;
    endtask

    // Drive inputs, take one rising edge, settle to the falling edge.
    task automatic tick(input logic s, input logic st);
        start = s;
        stop  = st;
        @(posedge clk);
        model_edge(s, st);
        @(negedge clk);
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({en, busy, done, pulse_cnt} !== {1'b0, 1'b0, 1'b0, {W{1'b0}}}) begin
            errors++;
            $display("[TB] FAIL reset: got en=%b busy=%b done=%b cnt=%0d, want all 0", en, busy, done, pulse_cnt);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_burst();
        int en_n = 0;
        int done_n = 0;
        int busy_n = 0;
        period = 8'd4; burst_len = 8'd3; mode = 1'b1;
        for (int i = 0; i < 14; i++) begin
            tick(i == 0, 1'b0);
            checks++;
            if ({en, busy, done, pulse_cnt} !== {exp_en, exp_busy, exp_done, exp_cnt}) begin
                errors++;
                $display("[TB] FAIL burst cyc %0d: got en=%b busy=%b done=%b cnt=%0d, want en=%b busy=%b done=%b cnt=%0d",
                         i + 1, en, busy, done, pulse_cnt, exp_en, exp_busy, exp_done, exp_cnt);
            end
            en_n   += int'(en);
            done_n += int'(done);
            busy_n += int'(busy);
        end
        checks++;
        if (en_n != 3 || done_n != 1 || busy_n != 9 || pulse_cnt !== 8'd3) begin
            errors++;
            $display("[TB] FAIL burst totals: got en=%0d done=%0d busy=%0d cnt=%0d, want 3 1 9 3", en_n, done_n, busy_n, pulse_cnt);
        end
    endtask

    task automatic test_continuous();
        int en_n = 0;
        int done_n = 0;
        period = 8'd0; mode = 1'b0;
        for (int i = 0; i < 25; i++) begin
            tick(i == 0, i == 20);
            checks++;
            if ({en, busy, done, pulse_cnt} !== {exp_en, exp_busy, exp_done, exp_cnt}) begin
                errors++;
                $display("[TB] FAIL continuous cyc %0d: got en=%b busy=%b done=%b cnt=%0d, want en=%b busy=%b done=%b cnt=%0d",
                         i + 1, en, busy, done, pulse_cnt, exp_en, exp_busy, exp_done, exp_cnt);
            end
            en_n   += int'(en);
            done_n += int'(done);
        end
        checks++;
        if (en_n != 19 || done_n != 0 || pulse_cnt !== 8'd19) begin
            errors++;
            $display("[TB] FAIL continuous totals: got en=%0d done=%0d cnt=%0d, want 19 0 19", en_n, done_n, pulse_cnt);
        end
    endtask

    task automatic test_start_stop_idle();
        int active = 0;
        period = 8'd1; mode = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick(1'b1, 1'b1);
            active += int'(en) + int'(busy);
        end
        checks++;
        if (active != 0 || exp_busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL start_stop_idle: got active cycles=%0d, want 0", active);
        end
    endtask

    task automatic test_start_in_run();
        int en_n = 0;
        period = 8'd4; mode = 1'b0;
        for (int i = 0; i < 23; i++) begin
            if (i == 6) period = 8'd2;
            tick(i < 20, i == 20);
            checks++;
            if ({en, busy, done, pulse_cnt} !== {exp_en, exp_busy, exp_done, exp_cnt}) begin
                errors++;
                $display("[TB] FAIL start_in_run cyc %0d: got en=%b busy=%b done=%b cnt=%0d, want en=%b busy=%b done=%b cnt=%0d",
                         i + 1, en, busy, done, pulse_cnt, exp_en, exp_busy, exp_done, exp_cnt);
            end
            en_n += int'(en);
        end
        checks++;
        if (en_n != 5) begin
            errors++;
            $display("[TB] FAIL start_in_run spacing: got strobes=%0d, want 5", en_n);
        end
    endtask

    task automatic test_abort_final();
        int en_n = 0;
        int done_n = 0;
        period = 8'd2; burst_len = 8'd2; mode = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick(i == 0, i == 3);
            checks++;
            if ({en, busy, done, pulse_cnt} !== {exp_en, exp_busy, exp_done, exp_cnt}) begin
                errors++;
                $display("[TB] FAIL abort_final cyc %0d: got en=%b busy=%b done=%b cnt=%0d, want en=%b busy=%b done=%b cnt=%0d",
                         i + 1, en, busy, done, pulse_cnt, exp_en, exp_busy, exp_done, exp_cnt);
            end
            en_n   += int'(en);
            done_n += int'(done);
        end
        checks++;
        if (en_n != 1 || done_n != 0) begin
            errors++;
            $display("[TB] FAIL abort_final totals: got en=%0d done=%0d, want 1 0", en_n, done_n);
        end
    endtask

    task automatic test_wrap();
        int  en_n = 0;
        bit  wrapped = 1'b0;
        logic [W-1:0] prev = '0;
        period = 8'd1; mode = 1'b0;
        for (int i = 0; i < 302; i++) begin
            tick(i == 0, i == 301);
            if (prev == 8'd255 && pulse_cnt == 8'd0) wrapped = 1'b1;
            prev = pulse_cnt;
            if ({en, busy, done, pulse_cnt} !== {exp_en, exp_busy, exp_done, exp_cnt}) begin
                errors++;
                $display("[TB] FAIL wrap cyc %0d: got en=%b busy=%b done=%b cnt=%0d, want en=%b busy=%b done=%b cnt=%0d",
                         i + 1, en, busy, done, pulse_cnt, exp_en, exp_busy, exp_done, exp_cnt);
            end
            en_n += int'(en);
        end
        checks += 302;
        checks++;
        if (en_n != 300 || !wrapped || pulse_cnt !== 8'd44) begin
            errors++;
            $display("[TB] FAIL wrap totals: got en=%0d wrapped=%0d cnt=%0d, want 300 1 44", en_n, wrapped, pulse_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int   done_n = 0;
        logic prev_done = 1'b0;
        period = 8'd2; burst_len = 8'd2; mode = 1'b1;
        for (int i = 0; i < 14; i++) begin
            tick(i < 12, i == 12);
            checks++;
            if ({en, busy, done, pulse_cnt} !== {exp_en, exp_busy, exp_done, exp_cnt}) begin
                errors++;
                $display("[TB] FAIL back_to_back cyc %0d: got en=%b busy=%b done=%b cnt=%0d, want en=%b busy=%b done=%b cnt=%0d",
                         i + 1, en, busy, done, pulse_cnt, exp_en, exp_busy, exp_done, exp_cnt);
            end
            if (prev_done && i < 12) begin
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL back_to_back restart cyc %0d: got busy=%b, want 1", i + 1, busy);
                end
            end
            prev_done = done;
            done_n += int'(done);
        end
        checks++;
        if (done_n != 3) begin
            errors++;
            $display("[TB] FAIL back_to_back dones: got %0d, want 3", done_n);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                period    = W'($urandom_range(0, 5));
                burst_len = W'($urandom_range(0, 4));
                mode      = 1'($urandom_range(0, 1));
            end
            tick($urandom_range(0, 2) == 0, $urandom_range(0, 11) == 0);
            checks++;
            if ({en, busy, done, pulse_cnt} !== {exp_en, exp_busy, exp_done, exp_cnt}) begin
                errors++;
                $display("[TB] FAIL random cyc %0d: got en=%b busy=%b done=%b cnt=%0d, want en=%b busy=%b done=%b cnt=%0d",
                         i + 1, en, busy, done, pulse_cnt, exp_en, exp_busy, exp_done, exp_cnt);
            end
        end
        tick(1'b0, 1'b1);
    endtask

    task automatic test_reset_midrun();
        period = 8'd3; burst_len = 8'd5; mode = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(i == 0, 1'b0);
        end
        checks++;
        if (busy !== 1'b1 || pulse_cnt !== exp_cnt) begin
            errors++;
            $display("[TB] FAIL reset_midrun pre: got busy=%b cnt=%0d, want busy=1 cnt=%0d", busy, pulse_cnt, exp_cnt);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({en, busy, done, pulse_cnt} !== {1'b0, 1'b0, 1'b0, {W{1'b0}}}) begin
            errors++;
            $display("[TB] FAIL reset_midrun async: got en=%b busy=%b done=%b cnt=%0d, want all 0", en, busy, done, pulse_cnt);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 8; i++) begin
            tick(1'b0, 1'b0);
            checks++;
            if ({en, busy, done, pulse_cnt} !== {exp_en, exp_busy, exp_done, exp_cnt}) begin
                errors++;
                $display("[TB] FAIL reset_midrun idle cyc %0d: got en=%b busy=%b done=%b cnt=%0d, want en=%b busy=%b done=%b cnt=%0d",
                         i + 1, en, busy, done, pulse_cnt, exp_en, exp_busy, exp_done, exp_cnt);
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        stop      = 1'b0;
        mode      = 1'b0;
        period    = '0;
        burst_len = '0;
        test_reset();
        test_burst();
        test_continuous();
        test_start_stop_idle();
        test_start_in_run();
        test_abort_final();
        test_wrap();
        test_back_to_back();
        test_random();
        test_reset_midrun();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
